par2ser_ramin: RTL

PAR2SER_RAMIN -- requirements
Module: par2ser_ramin

---
 rtl/par2ser_ramin.sv | 139 +++++++++++++
 1 files changed

// File: rtl/par2ser_ramin.sv
// Parallel-to-serial converter: accepts one multi-channel vector and streams it out
// SER_BW bits per channel per cycle, least significant word first, with a one-entry skid.
module par2ser_ramin #(
    parameter int unsigned NO_CH  = 10,
    parameter int unsigned BW_IN  = 12,
    parameter int unsigned SER_BW = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           vld_in,
    input  logic [NO_CH-1:0][BW_IN-1:0]    data_in,
    output logic                           rdy_in,
    output logic                           vld_out,
    output logic [NO_CH-1:0][SER_BW-1:0]   data_out,
    output logic                           last_out
);

    localparam int unsigned WORDS = BW_IN / SER_BW;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    typedef logic [NO_CH-1:0][BW_IN-1:0]  vec_t;
    typedef logic [NO_CH-1:0][SER_BW-1:0] word_t;
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    vec_t             shreg, shreg_nx;
    vec_t             pend, pend_nx;
    logic             pend_vld, pend_vld_nx;
    word_t            dout_nx;
    logic             vld_nx, last_nx;
    logic             accept_c, at_last_c, load_c, direct_c;
    vec_t             load_vec_c;

    function automatic word_t low_word(input vec_t v);
        word_t w;
        w = '0;
        for (int unsigned ch = 0; ch < NO_CH; ch++) begin
            w[ch] = v[ch][SER_BW-1:0];
        end
        return w;
    endfunction

    function automatic vec_t shift_down(input vec_t v);
        vec_t r;
        r = '0;
        for (int unsigned ch = 0; ch < NO_CH; ch++) begin
            r[ch] = v[ch] >> SER_BW;
        end
        return r;
    endfunction

    assign rdy_in    = ~pend_vld;
    assign accept_c  = vld_in & ~pend_vld;
    assign at_last_c = (state == SHIFT) && (cnt == LAST_IDX);

    // Next-state, shifter, skid and output word selection.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        shreg_nx    = shreg;
        pend_nx     = pend;
        pend_vld_nx = pend_vld;
        dout_nx     = data_out;
        load_c      = 1'b0;
        direct_c    = 1'b0;
        load_vec_c  = '0;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    load_c     = 1'b1;
                    direct_c   = 1'b1;
                    load_vec_c = data_in;
                end
            end
            SHIFT: begin
                if (at_last_c) begin
                    if (pend_vld) begin
                        load_c      = 1'b1;
                        load_vec_c  = pend;
                        pend_vld_nx = 1'b0;
                    end else if (accept_c) begin
                        load_c     = 1'b1;
                        direct_c   = 1'b1;
                        load_vec_c = data_in;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    dout_nx  = low_word(shreg);
                    shreg_nx = shift_down(shreg);
                    cnt_nx   = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (load_c) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
            dout_nx  = low_word(load_vec_c);
            shreg_nx = shift_down(load_vec_c);
        end

        // An accepted vector that the shifter cannot take now waits in the skid entry.
        if (accept_c && !direct_c) begin
            pend_nx     = data_in;
            pend_vld_nx = 1'b1;
        end

        vld_nx  = (state_nx == SHIFT);
        last_nx = (state_nx == SHIFT) && (cnt_nx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            vld_out  <= 1'b0;
            last_out <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            shreg    <= shreg_nx;
            pend     <= pend_nx;
            pend_vld <= pend_vld_nx;
            vld_out  <= vld_nx;
            last_out <= last_nx;
            data_out <= dout_nx;
        end
    end

endmodule
